// File: rtl/ts_sync_aligner_pkg.sv
// Shared constants and state type for the MPEG-TS sync aligner.
package ts_pkg;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam logic [7:0] TS_LEN_188   = 8'd188;
   localparam logic [7:0] TS_LEN_204   = 8'd204;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCK   = 2'd2
   } ts_state_e;

   function automatic logic [7:0] ts_last_pos(input logic len_188_204n);
      return len_188_204n ? (TS_LEN_188 - 8'd1) : (TS_LEN_204 - 8'd1);
   endfunction

endpackage

// File: rtl/ts_sync_aligner.sv
// Locks onto the TS sync byte at 188/204 spacing and emits framed bytes
// with one cycle of latency.
//
// state  | meaning
// HUNT   | searching the raw stream for a sync byte candidate
// VERIFY | candidate found, checking sync bytes at packet spacing
// LOCK   | aligned; bytes are output with sync/end framing
module ts_sync_aligner
   import ts_pkg::*;
#(
   parameter int unsigned LOCK_COUNT   = 3,
   parameter int unsigned UNLOCK_COUNT = 3,
   parameter logic [7:0]  SYNC_BYTE    = TS_SYNC_BYTE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_len_188_204n,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   output logic        o_ts_valid,
   output logic        o_ts_sync,
   output logic        o_ts_end,
   output logic [7:0]  o_ts_data,
   output logic        o_locked,
   output logic [15:0] o_loss_count
);

   localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

   ts_state_e   state;
   logic [7:0]  pos;
   logic [3:0]  good;
   logic [3:0]  bad;
   logic        len_q;

   logic [7:0]  last_pos;
   logic [7:0]  pos_next;
   logic [3:0]  good_inc;
   logic [3:0]  bad_inc;
   logic [15:0] loss_next;
   logic        is_sync;
   logic        len_changed;

   assign last_pos    = ts_last_pos(i_len_188_204n);
   assign pos_next    = (pos == last_pos) ? 8'd0 : pos + 8'd1;
   assign good_inc    = good + 4'd1;
   assign bad_inc     = bad + 4'd1;
   assign loss_next   = (o_loss_count == 16'hFFFF) ? o_loss_count : o_loss_count + 16'd1;
   assign is_sync     = (i_data == SYNC_BYTE);
   assign len_changed = (i_len_188_204n != len_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= HUNT;
         pos          <= 8'd0;
         good         <= 4'd0;
         bad          <= 4'd0;
         len_q        <= 1'b1;
         o_ts_valid   <= 1'b0;
         o_ts_sync    <= 1'b0;
         o_ts_end     <= 1'b0;
         o_ts_data    <= 8'd0;
         o_locked     <= 1'b0;
         o_loss_count <= 16'd0;
      end else begin
         len_q      <= i_len_188_204n;
         o_ts_valid <= 1'b0;
         o_ts_sync  <= 1'b0;
         o_ts_end   <= 1'b0;
         // A length change outranks whatever byte arrives in the same cycle.
         if (state != HUNT && len_changed) begin
            if (state == LOCK) begin
               o_loss_count <= loss_next;
            end
            state    <= HUNT;
            pos      <= 8'd0;
            good     <= 4'd0;
            bad      <= 4'd0;
            o_locked <= 1'b0;
         end else if (i_valid) begin
            case (state)
               HUNT: begin
                  if (is_sync) begin
                     state <= VERIFY;
                     pos   <= 8'd1;
                     good  <= 4'd1;
                  end
               end
               VERIFY: begin
                  if (pos != 8'd0) begin
                     pos <= pos_next;
                  end else if (is_sync) begin
                     good <= good_inc;
                     pos  <= pos_next;
                     if (good_inc == LOCK_N) begin
                        state      <= LOCK;
                        o_locked   <= 1'b1;
                        o_ts_valid <= 1'b1;
                        o_ts_sync  <= 1'b1;
                        o_ts_data  <= i_data;
                     end
                  end else begin
                     state <= HUNT;
                     good  <= 4'd0;
                  end
               end
               LOCK: begin
                  if (pos == 8'd0 && !is_sync && bad_inc == UNLOCK_N) begin
                     state        <= HUNT;
                     pos          <= 8'd0;
                     bad          <= 4'd0;
                     good         <= 4'd0;
                     o_locked     <= 1'b0;
                     o_loss_count <= loss_next;
                  end else begin
                     // Corrupt syncs below the threshold still pass through framed.
                     if (pos == 8'd0) begin
                        bad <= is_sync ? 4'd0 : bad_inc;
                     end
                     pos        <= pos_next;
                     o_ts_valid <= 1'b1;
                     o_ts_sync  <= (pos == 8'd0);
                     o_ts_end   <= (pos == last_pos);
                     o_ts_data  <= i_data;
                  end
               end
               default: begin
                  state <= HUNT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed bench for ts_sync_aligner: packet table plus length-change and reset sequences.
module tb_ts_sync_aligner;
   import ts_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_len_188_204n = 1'b1;
   logic        i_valid = 1'b0;
   logic [7:0]  i_data = 8'd0;
   logic        o_ts_valid;
   logic        o_ts_sync;
   logic        o_ts_end;
   logic [7:0]  o_ts_data;
   logic        o_locked;
   logic [15:0] o_loss_count;

   ts_sync_aligner dut (
      .clk            (clk),
      .rst            (rst),
      .i_len_188_204n (i_len_188_204n),
      .i_valid        (i_valid),
      .i_data         (i_data),
      .o_ts_valid     (o_ts_valid),
      .o_ts_sync      (o_ts_sync),
      .o_ts_end       (o_ts_end),
      .o_ts_data      (o_ts_data),
      .o_locked       (o_locked),
      .o_loss_count   (o_loss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst_before;
      bit          len188;
      logic [7:0]  sync;
      bit          gap;
      bit          false_pre;
      bit          lock0;
      bit          out;
      bit          lock_end;
      logic [15:0] loss;
   } pkt_t;

   pkt_t        tbl [31];
   int          tests = 0;
   int          fails = 0;
   logic [9:0]  exp_q [$];
   bit          pend = 1'b0;
   bit          pend_lock = 1'b0;
   logic [9:0]  mon_e;

   function automatic pkt_t mk(bit rb, bit l188, logic [7:0] s, bit g, bit fp,
                               bit l0, bit o, bit le, logic [15:0] ls);
      pkt_t r;
      r.rst_before = rb; r.len188 = l188; r.sync = s; r.gap = g; r.false_pre = fp;
      r.lock0 = l0; r.out = o; r.lock_end = le; r.loss = ls;
      return r;
   endfunction

   function automatic logic [7:0] pat(int k, int p);
      logic [7:0] d;
      d = 8'(p * 3 + k * 11);
      if (d == TS_SYNC_BYTE) d = 8'h5a;
      return d;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(bit v, logic [7:0] d);
      @(negedge clk);
      if (pend) begin
         pend = 1'b0;
         chk("byte0_locked", 32'(o_locked), 32'(pend_lock));
         chk("byte0_sync", 32'(o_ts_valid & o_ts_sync), 32'(pend_lock));
      end
      i_valid = v;
      i_data  = d;
   endtask

   task automatic send_byte(int p, int len, logic [7:0] d, bit out, bit gap);
      step(1'b1, d);
      if (out) exp_q.push_back({p == 0, p == len - 1, d});
      if (p == 0) pend = 1'b1;
      if (gap) step(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic run_pkts(int lo, int hi);
      for (int k = lo; k < hi; k++) begin
         pkt_t r;
         int   len;
         logic [7:0] d;
         r = tbl[k];
         len = r.len188 ? 188 : 204;
         if (r.rst_before) do_reset();
         i_len_188_204n = r.len188;
         if (r.false_pre) begin
            for (int j = 0; j < 100; j++) begin
               d = (j == 50) ? TS_SYNC_BYTE : 8'($urandom_range(0, 255));
               if (j != 50 && d == TS_SYNC_BYTE) d = 8'h00;
               step(1'b1, d);
            end
         end
         pend_lock = r.lock0;
         for (int p = 0; p < len; p++)
            send_byte(p, len, (p == 0) ? r.sync : pat(k, p), r.out, r.gap);
         step(1'b0, 8'h00);
         chk("pkt_queue_empty", 32'(exp_q.size()), 32'd0);
         chk("pkt_locked", 32'(o_locked), 32'(r.lock_end));
         chk("pkt_loss", 32'(o_loss_count), 32'(r.loss));
      end
   endtask

   // Output monitor: every output byte must match the next expected byte.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (o_ts_valid) begin
            chk("valid_mirror", 32'(i_valid), 32'd1);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %0h expected none at %0t", o_ts_data, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_byte", 32'({o_ts_sync, o_ts_end, o_ts_data}), 32'(mon_e));
            end
         end
      end
   end

   initial begin
      // 188-byte lock acquisition
      tbl[0]  = mk(1, 1, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 1, 8'h47, 0, 0, 1, 1, 1, 0);
      tbl[3]  = mk(0, 1, 8'h47, 0, 0, 1, 1, 1, 0);
      tbl[4]  = mk(0, 1, 8'h47, 0, 0, 1, 1, 1, 0);
      // 204-byte flywheel and unlock
      tbl[5]  = mk(1, 0, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 8'h47, 0, 0, 1, 1, 1, 0);
      tbl[8]  = mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0);
      tbl[9]  = mk(0, 0, 8'h47, 0, 0, 1, 1, 1, 0);
      tbl[10] = mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0);
      tbl[11] = mk(0, 0, 8'h01, 0, 0, 1, 1, 1, 0);
      tbl[12] = mk(0, 0, 8'h02, 0, 0, 0, 0, 0, 1);
      tbl[13] = mk(0, 0, 8'h47, 0, 0, 0, 0, 0, 1);
      tbl[14] = mk(0, 0, 8'h47, 0, 0, 0, 0, 0, 1);
      tbl[15] = mk(0, 0, 8'h47, 0, 0, 1, 1, 1, 1);
      // false sync at offset 50, real stream at offset 100
      tbl[16] = mk(1, 1, 8'h47, 0, 1, 0, 0, 0, 0);
      tbl[17] = mk(0, 1, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[18] = mk(0, 1, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 1, 8'h47, 0, 0, 1, 1, 1, 0);
      // gapped input
      tbl[20] = mk(1, 1, 8'h47, 1, 0, 0, 0, 0, 0);
      tbl[21] = mk(0, 1, 8'h47, 1, 0, 0, 0, 0, 0);
      tbl[22] = mk(0, 1, 8'h47, 1, 0, 1, 1, 1, 0);
      tbl[23] = mk(0, 1, 8'h47, 1, 0, 1, 1, 1, 0);
      // re-lock at 204 after mid-packet length change
      tbl[24] = mk(0, 0, 8'h47, 0, 0, 0, 0, 0, 1);
      tbl[25] = mk(0, 0, 8'h47, 0, 0, 0, 0, 0, 1);
      tbl[26] = mk(0, 0, 8'h47, 0, 0, 1, 1, 1, 1);
      // re-lock after async reset
      tbl[27] = mk(0, 0, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[28] = mk(0, 0, 8'h47, 0, 0, 0, 0, 0, 0);
      tbl[29] = mk(0, 0, 8'h47, 0, 0, 1, 1, 1, 0);
      tbl[30] = mk(0, 0, 8'h47, 0, 0, 1, 1, 1, 0);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(o_ts_valid), 32'd0);
      chk("rst_locked", 32'(o_locked), 32'd0);
      chk("rst_loss", 32'(o_loss_count), 32'd0);
      chk("rst_data", 32'(o_ts_data), 32'd0);
      rst = 1'b0;

      run_pkts(0, 24);

      // length change 100 bytes into a locked 188-byte packet
      pend_lock = 1'b1;
      for (int p = 0; p < 100; p++)
         send_byte(p, 188, (p == 0) ? TS_SYNC_BYTE : pat(24, p), 1'b1, 1'b0);
      step(1'b1, pat(24, 100));
      i_len_188_204n = 1'b0;
      step(1'b0, 8'h00);
      chk("lenchg_locked", 32'(o_locked), 32'd0);
      chk("lenchg_valid", 32'(o_ts_valid), 32'd0);
      chk("lenchg_loss", 32'(o_loss_count), 32'd1);
      chk("lenchg_queue", 32'(exp_q.size()), 32'd0);

      run_pkts(24, 27);

      // async reset 50 bytes into a locked 204-byte packet
      pend_lock = 1'b1;
      for (int p = 0; p < 50; p++)
         send_byte(p, 204, (p == 0) ? TS_SYNC_BYTE : pat(27, p), 1'b1, 1'b0);
      @(negedge clk);
      i_valid = 1'b0;
      chk("prerst_locked", 32'(o_locked), 32'd1);
      chk("prerst_loss", 32'(o_loss_count), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(o_ts_valid), 32'd0);
      chk("arst_sync", 32'(o_ts_sync), 32'd0);
      chk("arst_data", 32'(o_ts_data), 32'd0);
      chk("arst_locked", 32'(o_locked), 32'd0);
      chk("arst_loss", 32'(o_loss_count), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();

      run_pkts(27, 31);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ts_sync_aligner.md
Name: ts_sync_aligner

Overview:
- Upstream stage for the TS-over-IP packetiser. Accepts a raw, unframed MPEG-TS byte stream (e.g. from an ASI/SPI receiver) and locks onto the 0x47 sync byte at 188- or 204-byte spacing.
- Once locked, it emits framed bytes with a start-of-packet strobe. This output feeds the packetiser's i_ts_valid, i_ts_sync and i_ts_data inputs directly, in place of the test packet generator.
- It flywheels through isolated corrupted sync bytes and counts lock losses.

Parameters:
- LOCK_COUNT, 3: consecutive correctly spaced sync bytes needed to declare lock. Range 2..15.
- UNLOCK_COUNT, 3: consecutive bad sync positions needed to drop lock. Range 1..15.
- SYNC_BYTE, 8'h47: sync byte value.

Ports:
- clk  in  1  byte clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_len_188_204n  in  1  packet length select: 1 = 188 bytes, 0 = 204 bytes.
- i_valid  in  1  input byte qualifier.
- i_data  in  8  input byte.
- o_ts_valid  out  1  output byte qualifier.
- o_ts_sync  out  1  high with the first byte of each output packet.
- o_ts_end  out  1  high with the last byte of each output packet.
- o_ts_data  out  8  output byte.
- o_locked  out  1  high while in LOCK.
- o_loss_count  out  16  number of LOCK->HUNT transitions; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous): state = HUNT; pos, good and bad counters = 0; all outputs = 0, including o_ts_data and o_loss_count.
- Packet length: L = 188 when i_len_188_204n = 1, else 204. pos is an 8-bit position counter, 0..L-1, advanced only on i_valid; pos = 0 is the sync position. Cycles with i_valid low hold all state and give o_ts_valid = 0 on the next cycle.
- Latency: fixed 1 clk. All outputs are registered; o_ts_* reflect the i_* byte of the previous cycle.
- State HUNT, on each valid byte:
  - byte == SYNC_BYTE: go to VERIFY, pos = 1, good = 1.
  - otherwise stay in HUNT.
  - No output.
- State VERIFY, on each valid byte:
  - pos != 0: pos++ (wraps L-1 -> 0).
  - pos == 0 and byte == SYNC_BYTE: good++. If good reaches LOCK_COUNT, go to LOCK; this byte is output as the first locked byte with o_ts_sync = 1.
  - pos == 0 and byte != SYNC_BYTE: go to HUNT. The failing byte is not re-examined as a new sync candidate.
  - No output while in VERIFY.
- State LOCK, on each valid byte:
  - Output: o_ts_valid = 1, o_ts_data = byte, o_ts_sync = (pos == 0), o_ts_end = (pos == L-1).
  - At pos == 0: byte == SYNC_BYTE clears bad; otherwise bad++.
  - If bad reaches UNLOCK_COUNT: go to HUNT, o_loss_count++ (saturating), and do not output this byte. The preceding packet has already been fully output.
  - Corrupted sync bytes below the threshold are passed unmodified, with o_ts_sync still asserted.
- o_locked = (state == LOCK), registered; it rises in the same cycle as the first locked o_ts_sync.
- Length change: if i_len_188_204n changes while not in HUNT, go to HUNT in the next cycle and flush good/bad. If leaving LOCK this way, o_loss_count++.
- Simultaneous events: a length change takes priority over byte evaluation in the same cycle.
- Reset during LOCK: outputs drop immediately (asynchronously); a mid-packet truncation is acceptable, and downstream must tolerate it.

Decomposition:
- Shared package ts_pkg holds:
  - constants TS_SYNC_BYTE = 8'h47, TS_LEN_188 = 188, TS_LEN_204 = 204;
  - the state enum {HUNT, VERIFY, LOCK}.
- No sub-module is needed; a single module with one FSM, the position counter and an output register stage.

Test Plan:
- Lock acquisition: 5 clean 188-byte packets, i_valid always high, with i_len_188_204n = 1.
  - o_locked rises at the byte-0 of packet 3 plus 1 clk.
  - Packets 3–5 are output with o_ts_sync on byte 0 and o_ts_end on byte 187.
  - o_loss_count = 0.
- Flywheel and unlock: while locked at 204 bytes, corrupt sync bytes as follows.
  - One packet with sync = 8'h00: data passes unchanged and lock holds.
  - Three consecutive corrupted sync bytes: o_locked falls at the third; that byte is not output; o_loss_count = 1.
- False sync in HUNT: stream with 8'h47 at offset 50 of random data, then real packets starting at offset 100.
  - The false candidate fails VERIFY.
  - Lock is acquired on the real alignment after 3 packets.
- Gapped input: i_valid toggling 1/0 every cycle over clean 188-byte packets.
  - Lock is acquired.
  - Output bytes are contiguous in data order with o_ts_valid gaps mirroring the input.
  - Position counting is unaffected by the gaps.
- Length change: toggle i_len_188_204n mid-packet while locked.
  - Next cycle: state is HUNT, o_locked = 0, o_loss_count increments.
  - Re-lock occurs at the new length.
- Async reset: assert rst for 3 clks mid-packet while locked.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, lock needs 3 fresh sync bytes; o_loss_count = 0.
